// File: rtl/fib_pkg.sv
// Shared types and constants for the Fibonacci sequence generator.
package fib_pkg;

  localparam int unsigned FIB_SIZE = 4;

  localparam int unsigned F0 = 0;
  localparam int unsigned F1 = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fib_adder.sv
// SIZE-bit adder returning the sum and the carry out of the MSB.
module fib_adder
  import fib_pkg::*;
#(
  parameter int unsigned SIZE = FIB_SIZE
) (
  input  logic [SIZE-1:0] i_a,
  input  logic [SIZE-1:0] i_b,
  output logic [SIZE-1:0] o_sum,
  output logic            o_carry
);

  logic [SIZE:0] w_full;

  assign w_full  = {1'b0, i_a} + {1'b0, i_b};
  assign o_sum   = w_full[SIZE-1:0];
  assign o_carry = w_full[SIZE];

endmodule

// File: rtl/fib_seq_gen.sv
// Streams F(0)..F(n) over valid/ready; stops early, flagging ovf, before a term
// that would wrap SIZE bits.
module fib_seq_gen
  import fib_pkg::*;
#(
  parameter int unsigned SIZE = FIB_SIZE
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [SIZE-1:0] n,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [SIZE-1:0] out_term,
  output logic [SIZE-1:0] out_idx,
  output logic            busy,
  output logic            done,
  output logic            ovf
);

  state_t          r_state;
  state_t          w_next;
  logic [SIZE-1:0] r_a;
  logic [SIZE-1:0] r_b;
  logic [SIZE-1:0] r_idx;
  logic [SIZE-1:0] r_n_q;
  logic            r_a_ovf;
  logic            r_b_ovf;
  logic            r_ovf;

  logic [SIZE-1:0] w_sum;
  logic            w_carry;
  logic            w_xfer;
  logic            w_last;
  logic            w_stop_ovf;

  fib_adder #(.SIZE(SIZE)) u_adder (
    .i_a    (r_a),
    .i_b    (r_b),
    .o_sum  (w_sum),
    .o_carry(w_carry)
  );

  assign w_xfer     = (r_state == EMIT) && out_ready;
  assign w_last     = (r_idx == r_n_q);
  // b already holds a wrapped term, so the next term must not be shown
  assign w_stop_ovf = r_b_ovf | r_a_ovf;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (start) w_next = EMIT;
      EMIT:    if (w_xfer && (w_last || w_stop_ovf)) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a     <= SIZE'(F0);
      r_b     <= SIZE'(F1);
      r_idx   <= '0;
      r_n_q   <= '0;
      r_a_ovf <= 1'b0;
      r_b_ovf <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_n_q   <= n;
            r_a     <= SIZE'(F0);
            r_b     <= SIZE'(F1);
            r_idx   <= '0;
            r_a_ovf <= 1'b0;
            r_b_ovf <= 1'b0;
            r_ovf   <= 1'b0;
          end
        end
        EMIT: begin
          if (w_xfer && !w_last) begin
            if (w_stop_ovf) begin
              r_ovf <= 1'b1;
            end else begin
              r_a     <= r_b;
              r_b     <= w_sum;
              r_a_ovf <= r_b_ovf;
              r_b_ovf <= r_b_ovf | w_carry;
              r_idx   <= r_idx + SIZE'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid = (r_state == EMIT);
  assign busy      = (r_state == EMIT);
  assign done      = (r_state == DONE);
  assign out_term  = r_a;
  assign out_idx   = r_idx;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_fib_seq_gen.sv
// Directed and randomized checks of fib_seq_gen against an arithmetic Fibonacci model.
module tb_fib_seq_gen;

  localparam int SIZE = 4;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic [SIZE-1:0] n;
  logic            out_ready;
  logic            out_valid;
  logic [SIZE-1:0] out_term;
  logic [SIZE-1:0] out_idx;
  logic            busy;
  logic            done;
  logic            ovf;

  int n_tests = 0;
  int n_fail  = 0;

  int exp_q[$];
  bit exp_ovf;

  fib_seq_gen #(.SIZE(SIZE)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .n        (n),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_term (out_term),
    .out_idx  (out_idx),
    .busy     (busy),
    .done     (done),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Every F(i), i<=nn, that fits in SIZE bits is emitted; a larger one means truncation.
  task automatic model(input int nn);
    int f0, f1, t;
    exp_q.delete();
    exp_ovf = 1'b0;
    f0 = 0;
    f1 = 1;
    for (int i = 0; i <= nn; i++) begin
      if (f0 >= (1 << SIZE)) begin
        exp_ovf = 1'b1;
        break;
      end
      exp_q.push_back(f0);
      t  = f0 + f1;
      f0 = f1;
      f1 = t;
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 0);
    chk({tag, "_term"},  32'(out_term),  0);
    chk({tag, "_idx"},   32'(out_idx),   0);
    chk({tag, "_busy"},  32'(busy),      0);
    chk({tag, "_done"},  32'(done),      0);
    chk({tag, "_ovf"},   32'(ovf),       0);
  endtask

  // Runs one sequence from IDLE. stall_at: hold ready low 3 cycles at that idx;
  // poke_at: pulse start (with a different n) at that idx; rst_at: reset at that idx.
  task automatic run_seq(input string tag, input int nn, input int rdy_pct,
                         input int stall_at, input int poke_at, input int rst_at);
    int k, cyc, stalls, len;
    model(nn);
    len    = exp_q.size();
    k      = 0;
    cyc    = 0;
    stalls = 0;
    @(negedge clk);
    start     = 1'b1;
    n         = SIZE'(nn);
    out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    while (k < len) begin
      if (cyc >= 400) begin
        n_tests++;
        n_fail++;
        $error("FAIL %s_timeout observed=%0d expected=%0d", tag, k, len);
        break;
      end
      chk({tag, "_valid"}, 32'(out_valid), 1);
      chk({tag, "_busy"},  32'(busy),      1);
      chk({tag, "_done"},  32'(done),      0);
      chk({tag, "_term"},  32'(out_term),  32'(exp_q[k]));
      chk({tag, "_idx"},   32'(out_idx),   32'(k));
      if (k == rst_at) begin
        rst_n     = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        chk_reset_state({tag, "_rst"});
        out_ready = 1'b0;
        return;
      end
      start = (k == poke_at);
      n     = (k == poke_at) ? SIZE'($urandom_range(15)) : SIZE'(nn);
      if (k == stall_at && stalls < 3) begin
        out_ready = 1'b0;
        stalls++;
      end else begin
        out_ready = ($urandom_range(99) < rdy_pct);
      end
      if (out_ready) k++;
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_done_pulse"}, 32'(done),      1);
    chk({tag, "_done_valid"}, 32'(out_valid), 0);
    chk({tag, "_done_ovf"},   32'(ovf),       32'(exp_ovf));
    // A start during DONE must be dropped.
    start     = 1'b1;
    n         = SIZE'(3);
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_idle_done"},  32'(done),      0);
    chk({tag, "_idle_busy"},  32'(busy),      0);
    chk({tag, "_idle_valid"}, 32'(out_valid), 0);
    @(negedge clk);
    chk({tag, "_idle_ovf"},   32'(ovf),       32'(exp_ovf));
    chk({tag, "_idle_valid2"}, 32'(out_valid), 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    n         = '0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_reset_state("reset");
    rst_n = 1'b1;

    run_seq("t1_n7",      7, 100, -1, -1, -1);
    run_seq("t2_n10_ovf", 10, 100, -1, -1, -1);
    run_seq("t3_n0",      0, 100, -1, -1, -1);
    run_seq("t4_stall",   5, 100,  3, -1, -1);
    run_seq("t5_poke",    6, 100, -1,  2, -1);
    run_seq("t5_n2",      2, 100, -1, -1, -1);
    run_seq("t6_rst",     7, 100, -1, -1,  4);
    run_seq("t6_n1",      1, 100, -1, -1, -1);
    run_seq("max_n15",   15,  70, -1, -1, -1);

    for (int i = 0; i < 30; i++) begin
      run_seq("rand", int'($urandom_range(15)), int'($urandom_range(100, 30)),
              int'($urandom_range(8)), -1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fib_seq_gen.md
Name: fib_seq_gen

Overview:
Sequential Fibonacci term generator. On a start request it streams F(0)..F(n) one term per accepted transfer over a valid/ready output. It sits directly upstream of the 4-to-1 display/select mux, which consumes out_term as one of its SIZE-bit data inputs. It detects SIZE-bit overflow and stops before emitting a wrapped term.

Parameters:
SIZE, 4, width of n, out_term and out_idx, and of internal term registers.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  synchronous active-low reset.
start  in  1  request a new sequence; sampled only in IDLE.
n  in  SIZE  index of the last term to emit; latched on accepted start.
out_ready  in  1  downstream accepts the current term.
out_valid  out  1  out_term/out_idx valid.
out_term  out  SIZE  current Fibonacci term.
out_idx  out  SIZE  index of out_term.
busy  out  1  high while in EMIT.
done  out  1  one-cycle pulse at end of sequence.
ovf  out  1  sequence truncated by overflow; held until next accepted start.

Behaviour:
- Interface: one clock (clk); reset rst_n is synchronous and active-low. All state changes on rising clk only.
- Reset, applied at any time including mid-sequence:
  - State goes to IDLE on the next edge.
  - out_valid=0, out_term=0, out_idx=0, busy=0, done=0, ovf=0.
  - Internal registers: a=0, b=1, a_ovf=0, b_ovf=0, n_q=0.
- States: IDLE, EMIT, DONE.
- IDLE:
  - If start=1: n_q<=n, a<=0, b<=1, idx<=0, a_ovf<=0, b_ovf<=0, ovf<=0, then go to EMIT.
  - Otherwise stay in IDLE.
- EMIT:
  - out_valid=1, out_term=a, out_idx=idx, busy=1.
  - Transfer occurs when out_valid && out_ready.
  - No transfer: all registers hold; out_term and out_idx stay stable.
  - Transfer with idx==n_q: go to DONE, ovf stays 0.
  - Transfer with idx!=n_q and b_ovf=1: ovf<=1, go to DONE. The wrapped term is never presented.
  - Transfer otherwise: a<=b, b<=a+b (low SIZE bits), b_ovf<=b_ovf | carry_out(a+b), idx<=idx+1, stay in EMIT.
  - The adder is SIZE+1 bits; carry is the MSB.
- DONE:
  - done=1 and out_valid=0 for exactly one cycle, then go to IDLE.
  - ovf holds its value through IDLE until the next accepted start.
- start is ignored in EMIT and DONE; no queuing.
- Latency: start high in cycle k gives out_valid=1 with F(0)=0 in cycle k+1. With out_ready held high, one term is emitted per cycle.
- n=0: exactly one term (0), then done.
- out_valid, busy and done are registered outputs, and out_term/out_idx are registered — no combinational path from any input to any output.
- out_valid may not drop without a transfer, except on reset.
- Max representable term for SIZE=4 is 13 (F(7)); F(8)=21 triggers ovf.

Decomposition:
- Package fib_pkg:
  - state enum (IDLE, EMIT, DONE) with 2-bit encoding;
  - default SIZE constant;
  - F0=0 and F1=1 seed constants.
- One sub-module, fib_adder: SIZE-bit adder producing {carry, sum}.
- FSM and registers stay in fib_seq_gen.

Test Plan:
1. rst_n=0 for 2 cycles, then n=7, start pulse, out_ready=1 → out_term 0,1,1,2,3,5,8,13 on 8 consecutive cycles; out_idx 0..7; then done=1 for one cycle; ovf=0; busy low after DONE.
2. n=10, out_ready=1 → terms 0..13 (8 terms, idx 0..7), no 21 presented; ovf=1 and done pulse one cycle after the idx=7 transfer; ovf remains 1 in IDLE.
3. n=0 → single transfer with out_term=0, out_idx=0; done the next cycle; ovf=0.
4. n=5, out_ready=0 for 3 cycles while out_idx=3 → out_valid=1, out_term=2 and out_idx=3 held stable all 3 cycles; sequence resumes with 3, then 5.
5. n=6, second start pulse while busy at idx=2 → ignored; sequence completes normally to 8 with a single done pulse; a subsequent start in IDLE with n=2 emits 0,1,1.
6. n=7, rst_n=0 for 1 cycle at idx=4 → next cycle out_valid=0, out_term=0, out_idx=0, busy=0, done=0, ovf=0; a fresh start with n=1 emits 0,1 then done.
